// File: rtl/alu_sweep_checker.sv
// -----------------------------------------------------------------------------
// alu_sweep_checker
//   In-system exhaustive checker for a 3-bit ALU. The block walks every
//   {sel,A,B} combination (0x00..0xFF) and drives each one to the ALU. After
//   SETTLE cycles it samples the 6-bit ALU result and compares it with a
//   built-in golden model. It counts mismatches and captures the first one.
//
// Parameters
//   SETTLE        cycles between driving a vector and sampling alu_op (>=1)
//   STOP_ON_FAIL  1: end the sweep at the first mismatch, 0: run all vectors
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   request to begin a sweep (pulse or level)
//   alu_sel        out  sel operand driven to the ALU
//   alu_a          out  A operand driven to the ALU
//   alu_b          out  B operand driven to the ALU
//   alu_op         in   result returned by the ALU
//   busy           out  sweep in progress
//   done           out  sweep finished, held until next start or reset
//   pass           out  valid with done: no mismatches seen
//   err_count      out  number of mismatching vectors
//   first_fail_vec out  {sel,A,B} of the first mismatch (0 if none)
//   first_fail_op  out  alu_op captured at the first mismatch (0 if none)
// -----------------------------------------------------------------------------
module alu_sweep_checker #(
  parameter int SETTLE       = 2,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] alu_sel,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  input  logic [5:0] alu_op,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] first_fail_vec,
  output logic [5:0] first_fail_op
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Settle counter only needs to reach SETTLE-1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(SETTLE - 1);

  state_t        r_state;
  logic [7:0]    r_idx;
  logic [CW-1:0] r_wait_cnt;

  logic [5:0]    w_golden;
  logic          w_mismatch;
  logic [7:0]    w_idx_next;
  logic [8:0]    w_err_inc;
  logic          w_last_vec;
  logic          w_stop;

  // Reference ALU: all results are taken modulo 64.
  function automatic logic [5:0] golden_op(input logic [7:0] vec);
    logic [1:0] sel;
    logic [5:0] a6;
    logic [5:0] b6;
    sel = vec[7:6];
    a6  = {3'b000, vec[5:3]};
    b6  = {3'b000, vec[2:0]};
    case (sel)
      2'b00:   golden_op = a6 + b6;
      2'b01:   golden_op = a6 - b6;
      2'b10:   golden_op = a6 * b6;
      2'b11:   golden_op = {vec[5:3] & vec[2:0], vec[5:3] | vec[2:0]};
      default: golden_op = 6'd0;
    endcase
  endfunction

  assign w_golden   = golden_op(r_idx);
  assign w_mismatch = (alu_op != w_golden);
  assign w_idx_next = r_idx + 8'd1;
  assign w_err_inc  = err_count + 9'd1;
  assign w_last_vec = (r_idx == 8'hFF);
  assign w_stop     = w_last_vec || (STOP_ON_FAIL && w_mismatch);

  // Sweep sequencer; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= 8'd0;
      r_wait_cnt     <= '0;
      alu_sel        <= 2'd0;
      alu_a          <= 3'd0;
      alu_b          <= 3'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 9'd0;
      first_fail_vec <= 8'd0;
      first_fail_op  <= 6'd0;
    end else begin
      case (r_state)
        // A finished sweep restarts exactly like an idle one.
        ST_IDLE, ST_FIN: begin
          if (start) begin
            r_state        <= ST_DRIVE;
            r_idx          <= 8'd0;
            r_wait_cnt     <= '0;
            alu_sel        <= 2'd0;
            alu_a          <= 3'd0;
            alu_b          <= 3'd0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 9'd0;
            first_fail_vec <= 8'd0;
            first_fail_op  <= 6'd0;
          end else begin
            r_state <= r_state;
          end
        end
        // The vector was loaded on entry, so it is visible during DRIVE.
        ST_DRIVE: begin
          r_state    <= ST_WAIT;
          r_wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_state <= ST_CHECK;
          end else begin
            r_wait_cnt <= r_wait_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            err_count <= w_err_inc;
            if (err_count == 9'd0) begin
              first_fail_vec <= r_idx;
              first_fail_op  <= alu_op;
            end else begin
              first_fail_vec <= first_fail_vec;
            end
          end else begin
            err_count <= err_count;
          end
          if (w_stop) begin
            r_state <= ST_FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (!w_mismatch) && (err_count == 9'd0);
          end else begin
            r_state <= ST_DRIVE;
            r_idx   <= w_idx_next;
            alu_sel <= w_idx_next[7:6];
            alu_a   <= w_idx_next[5:3];
            alu_b   <= w_idx_next[2:0];
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_alu_sweep_checker
//   Two checker instances (STOP_ON_FAIL=0 and =1) each drive a behavioural
//   ALU that can be made faulty (result inverted when sel=11). Each start
//   pushes an expected sweep result into a per-instance queue. A monitor pops
//   and compares whenever that instance raises done.
// -----------------------------------------------------------------------------
module tb_alu_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic fault;

  always #5 clk = ~clk;

  logic [1:0] sel0, sel1;
  logic [2:0] a0, b0, a1, b1;
  logic [5:0] op0, op1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [8:0] ec0, ec1;
  logic [7:0] fv0, fv1;
  logic [5:0] fo0, fo1;

  alu_sweep_checker #(.SETTLE(2), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_sel(sel0), .alu_a(a0), .alu_b(b0), .alu_op(op0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
    .first_fail_vec(fv0), .first_fail_op(fo0)
  );

  alu_sweep_checker #(.SETTLE(2), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_sel(sel1), .alu_a(a1), .alu_b(b1), .alu_op(op1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .first_fail_vec(fv1), .first_fail_op(fo1)
  );

  // Behavioural ALU in integer arithmetic, optionally faulty for sel=11.
  function automatic logic [5:0] ref_alu(input logic [1:0] s, input logic [2:0] a,
                                         input logic [2:0] b, input logic f);
    int r;
    logic [5:0] res;
    case (s)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b);
      2'd2:    r = int'(a) * int'(b);
      default: r = int'(a & b) * 8 + int'(a | b);
    endcase
    r   = r & 63;
    res = r[5:0];
    if (f && s == 2'd3) res = ~res;
    return res;
  endfunction

  assign op0 = ref_alu(sel0, a0, b0, fault);
  assign op1 = ref_alu(sel1, a1, b1, fault);

  typedef struct {
    int         issue;
    int         lat;
    int         err;
    logic       pass;
    logic [7:0] ffv;
    logic [5:0] ffo;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic chk_res(input string tag, input exp_t e, input int latency,
                         input logic [8:0] ec, input logic p,
                         input logic [7:0] fv, input logic [5:0] fo);
    chk({tag, " latency"}, latency, e.lat);
    chk({tag, " err_count"}, ec, e.err);
    chk({tag, " pass"}, p, e.pass);
    chk({tag, " first_fail_vec"}, fv, e.ffv);
    chk({tag, " first_fail_op"}, fo, e.ffo);
  endtask

  // Monitor for instance 0: compare on each rising edge of done.
  logic pd0 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done0 && !pd0) begin
      if (q0.size() == 0) chk("dut0 unexpected done", 1, 0);
      else begin
        e = q0.pop_front();
        chk_res("dut0", e, cyc - e.issue, ec0, pass0, fv0, fo0);
      end
    end
    pd0 = done0;
  end

  // Monitor for instance 1: compare on each rising edge of done.
  logic pd1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done1 && !pd1) begin
      if (q1.size() == 0) chk("dut1 unexpected done", 1, 0);
      else begin
        e = q1.pop_front();
        chk_res("dut1", e, cyc - e.issue, ec1, pass1, fv1, fo1);
      end
    end
    pd1 = done1;
  end

  task automatic issue(input exp_t e0, input exp_t e1);
    @(negedge clk);
    start = 1'b1;
    e0.issue = cyc + 1;
    e1.issue = cyc + 1;
    q0.push_back(e0);
    q1.push_back(e1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_both(input string name, input int budget);
    int n = 0;
    while (!(done0 && done1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, " finished within budget"}, done0 && done1, 1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " dut0 outputs zero"}, {sel0, a0, b0, busy0, done0, pass0, ec0, fv0, fo0}, 0);
    chk({name, " dut1 outputs zero"}, {sel1, a1, b1, busy1, done1, pass1, ec1, fv1, fo1}, 0);
  endtask

  exp_t good, bad_all, bad_stop;

  initial begin
    good     = '{issue: 0, lat: 1024, err: 0,  pass: 1'b1, ffv: 8'h00, ffo: 6'h00};
    bad_all  = '{issue: 0, lat: 1024, err: 64, pass: 1'b0, ffv: 8'hC0, ffo: 6'h3F};
    bad_stop = '{issue: 0, lat: 772,  err: 1,  pass: 1'b0, ffv: 8'hC0, ffo: 6'h3F};

    // T1: reset held with start asserted, then release without start.
    rst_n = 1'b0;
    start = 1'b1;
    fault = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("T1 in reset");
    start = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_zero("T1 idle after reset");

    // Golden ALU spot values from the reference model.
    chk("golden sel0 A2 B7", ref_alu(2'd0, 3'd2, 3'd7, 1'b0), 6'h09);
    chk("golden sel1 A2 B7", ref_alu(2'd1, 3'd2, 3'd7, 1'b0), 6'h3B);
    chk("golden sel2 A2 B7", ref_alu(2'd2, 3'd2, 3'd7, 1'b0), 6'h0E);
    chk("golden sel3 A2 B7", ref_alu(2'd3, 3'd2, 3'd7, 1'b0), 6'h17);

    // T2 + T6: good sweep with start pulses while busy.
    issue(good, good);
    repeat (10) @(negedge clk);
    chk("T6 busy during sweep", {busy0, busy1}, 2'b11);
    pulse_start();
    repeat (300) @(negedge clk);
    pulse_start();
    repeat (600) @(negedge clk);
    pulse_start();
    wait_both("T2", 1200);

    // T6: restart from FIN gives an identical sweep.
    issue(good, good);
    wait_both("T6 second sweep", 1200);

    // T3/T4: inverted result for sel=11.
    fault = 1'b1;
    issue(bad_all, bad_stop);
    wait_both("T3/T4", 1200);
    fault = 1'b0;

    // T5: reset at vector 0x64, then a fresh full sweep.
    issue(good, good);
    begin
      int n = 0;
      while ({sel0, a0, b0} != 8'h64 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("T5 reached vector 0x64", {sel0, a0, b0}, 8'h64);
    end
    rst_n = 1'b0;
    #1;
    chk_zero("T5 mid-sweep reset");
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(good, good);
    wait_both("T5 fresh sweep", 1200);

    repeat (3) @(negedge clk);
    chk("dut0 all results seen", q0.size(), 0);
    chk("dut1 all results seen", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
